// File: rtl/reg_scoreboard_pkg.sv
// Shared GPR constants and helpers for the register scoreboard.
// Register 0 is the hard-wired zero register and is never tracked.
package reg_scoreboard_pkg;

    localparam int GPR_NUM = 32;
    localparam int ADDR_W  = 5;

    typedef logic [ADDR_W-1:0] gpr_addr_t;

    localparam gpr_addr_t ZERO_REG = '0;

    // A write only occupies a scoreboard entry when it targets a real register.
    function automatic logic writes_gpr(input logic we, input gpr_addr_t waddr);
        return we && (waddr != ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One in-flight writer counter: two increment and two decrement requests per
// cycle, netted in a single update, clamped to [0, CMAX], with clear priority.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    localparam int W = CNT_W + 2;
    localparam logic [W-1:0] CMAX = {2'b00, {CNT_W{1'b1}}};

    logic [W-1:0] up_sum;
    logic [W-1:0] dn_sum;
    logic [W-1:0] next_cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        up_sum    = {2'b00, count} + W'(inc[0]) + W'(inc[1]);
        dn_sum    = W'(dec[0]) + W'(dec[1]);
        next_cnt  = '0;
        underflow = 1'b0;
        if (clr) begin
            next_cnt = '0;
        end else if (dn_sum > up_sum) begin
            underflow = 1'b1;
        end else begin
            next_cnt = up_sum - dn_sum;
            if (next_cnt > CMAX) next_cnt = CMAX;
        end
    end

    // NOTE: state registers use non-blocking assignments so all counters update together.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) count <= '0;
        else          count <= next_cnt[CNT_W-1:0];
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue GPR scoreboard: tracks in-flight writers per register, gates
// issue on RAW/capacity hazards, and reports busy registers and stalls.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              issue0_valid,
    input  logic              issue0_we,
    input  logic [ADDR_W-1:0] issue0_waddr,
    input  logic [ADDR_W-1:0] issue0_raddr1,
    input  logic [ADDR_W-1:0] issue0_raddr2,
    output logic              issue0_ready,
    input  logic              issue1_valid,
    input  logic              issue1_we,
    input  logic [ADDR_W-1:0] issue1_waddr,
    input  logic [ADDR_W-1:0] issue1_raddr1,
    input  logic [ADDR_W-1:0] issue1_raddr2,
    output logic              issue1_ready,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_waddr,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_waddr,
    input  logic              flush,
    output logic [GPR_NUM-1:0] busy_mask,
    output logic [31:0]       stall_cnt,
    output logic              underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   CNT_MAX_EXT = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0]   cnt [GPR_NUM];
    logic [GPR_NUM-1:0] uf_vec;

    logic writes0;
    logic writes1;
    logic fire0;
    logic fire1;
    logic src0_clear;
    logic src1_clear;
    logic room0;
    logic room1;
    logic raw_hazard;
    logic same_dst;
    logic [CNT_W:0] dst1_level;

    assign cnt[0]       = '0;
    assign uf_vec[0]    = 1'b0;
    assign busy_mask[0] = 1'b0;

    assign writes0 = writes_gpr(issue0_we, issue0_waddr);
    assign writes1 = writes_gpr(issue1_we, issue1_waddr);

    // Readiness looks only at registered counters; same-cycle write-backs free nothing yet.
    always_comb begin
        src0_clear   = (cnt[issue0_raddr1] == '0) && (cnt[issue0_raddr2] == '0);
        room0        = !writes0 || (cnt[issue0_waddr] != CNT_MAX);
        issue0_ready = aresetn && src0_clear && room0;
        fire0        = issue0_valid && issue0_ready;

        src1_clear   = (cnt[issue1_raddr1] == '0) && (cnt[issue1_raddr2] == '0);
        raw_hazard   = writes0 && ((issue1_raddr1 == issue0_waddr) ||
                                   (issue1_raddr2 == issue0_waddr));
        same_dst     = fire0 && writes0 && (issue1_waddr == issue0_waddr);
        dst1_level   = {1'b0, cnt[issue1_waddr]} + (CNT_W+1)'(same_dst);
        room1        = !writes1 || (dst1_level < CNT_MAX_EXT);
        issue1_ready = fire0 && src1_clear && !raw_hazard && room1;
        fire1        = issue1_valid && issue1_ready;
    end

    for (genvar i = 1; i < GPR_NUM; i++) begin : g_reg
        logic [1:0] inc;
        logic [1:0] dec;

        assign inc[0] = fire0 && writes0 && (issue0_waddr == ADDR_W'(i));
        assign inc[1] = fire1 && writes1 && (issue1_waddr == ADDR_W'(i));
        assign dec[0] = wb0_valid && (wb0_waddr == ADDR_W'(i));
        assign dec[1] = wb1_valid && (wb1_waddr == ADDR_W'(i));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .aresetn   (aresetn),
            .inc       (inc),
            .dec       (dec),
            .clr       (flush),
            .count     (cnt[i]),
            .underflow (uf_vec[i])
        );

        assign busy_mask[i] = |cnt[i];
    end

    // Stall count survives flush; only reset clears it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt     <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (|uf_vec) underflow_err <= 1'b1;
            if (issue0_valid && !issue0_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
